// File: rtl/popcount_shift_accumulator_if.sv
// Beat-in / result-out handshake bundle for the popcount shift accumulator.
// The master drives beats and the downstream ready; the slave returns
// the saturated per-channel results.
interface popcount_shift_accumulator_if #(
    parameter int NO_CH  = 64,
    parameter int BW_IN  = 12,
    parameter int BW_OUT = 16,
    parameter int L2     = 3
);
    logic [L2-1:0]                  cfg_len;
    logic                           flush;
    logic                           in_vld;
    logic                           in_rdy;
    logic [NO_CH-1:0][BW_IN-1:0]    data_in;
    logic                           out_vld;
    logic                           out_rdy;
    logic [NO_CH-1:0][BW_OUT-1:0]   data_out;
    logic [NO_CH-1:0]               sat_out;

    modport master (
        output cfg_len, flush, in_vld, data_in, out_rdy,
        input  in_rdy, out_vld, data_out, sat_out
    );

    modport slave (
        input  cfg_len, flush, in_vld, data_in, out_rdy,
        output in_rdy, out_vld, data_out, sat_out
    );
endinterface

// File: rtl/popcount_shift_accumulator.sv
// Per-channel signed accumulator. It combines 1..MAX_CYC beats into one
// saturated result per frame. Beat k is weighted by 2^(k*SHIFT), so
// SHIFT=0 gives a plain sum.
module popcount_shift_accumulator #(
    parameter int NO_CH   = 64,
    parameter int BW_IN   = 12,
    parameter int BW_OUT  = 16,
    parameter int MAX_CYC = 8,
    parameter int SHIFT   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    popcount_shift_accumulator_if.slave bus
);
    localparam int L2    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int ACC_W = BW_IN + (MAX_CYC - 1) * SHIFT + L2 + 1;
    // The compare width covers both the accumulator and the output range.
    // This keeps the clamp bounds representable for any parameter mix.
    localparam int CMP_W = ((ACC_W > BW_OUT) ? ACC_W : BW_OUT) + 1;
    localparam logic [L2-1:0] LEN_MAX = L2'(MAX_CYC - 1);
    localparam logic signed [CMP_W-1:0] SAT_HI = {{(CMP_W-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_LO = {{(CMP_W-BW_OUT+1){1'b1}}, {(BW_OUT-1){1'b0}}};

    logic [L2-1:0]                 cnt;
    logic [L2-1:0]                 len;
    logic signed [ACC_W-1:0]       acc     [NO_CH];
    logic signed [ACC_W-1:0]       acc_nxt [NO_CH];
    logic [NO_CH-1:0][BW_OUT-1:0]  dout_q;
    logic [NO_CH-1:0][BW_OUT-1:0]  dout_d;
    logic [NO_CH-1:0]              sat_q;
    logic [NO_CH-1:0]              sat_d;
    logic                          out_vld_q;

    logic [L2-1:0]                 cfg_len_c;
    logic [L2-1:0]                 len_eff;
    logic                          first;
    logic                          in_rdy_w;
    logic                          take_beat;
    logic                          last;
    logic signed [ACC_W-1:0]       term;
    logic signed [CMP_W-1:0]       wide;
    int                            shamt;

    // Handshake, frame bookkeeping, weighted sums and output clamping
    always_comb begin
        cfg_len_c = (int'(bus.cfg_len) > MAX_CYC - 1) ? LEN_MAX : bus.cfg_len;
        first     = (cnt == '0);
        len_eff   = first ? cfg_len_c : len;
        in_rdy_w  = ~out_vld_q | bus.out_rdy;
        take_beat = bus.in_vld & in_rdy_w & ~bus.flush;
        last      = take_beat & (cnt == len_eff);
        shamt     = int'(cnt) * SHIFT;
        term      = '0;
        wide      = '0;
        dout_d    = '0;
        sat_d     = '0;
        for (int ch = 0; ch < NO_CH; ch++) begin
            term        = ACC_W'(signed'(bus.data_in[ch]));
            term        = term <<< shamt;
            acc_nxt[ch] = first ? term : acc[ch] + term;
            wide        = CMP_W'(acc_nxt[ch]);
            if (wide > SAT_HI) begin
                dout_d[ch] = SAT_HI[BW_OUT-1:0];
                sat_d[ch]  = 1'b1;
            end else if (wide < SAT_LO) begin
                dout_d[ch] = SAT_LO[BW_OUT-1:0];
                sat_d[ch]  = 1'b1;
            end else begin
                dout_d[ch] = wide[BW_OUT-1:0];
            end
        end
    end

    // Beat counter and frame length, latched on the first beat of a frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            len <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else if (take_beat) begin
            if (first) len <= cfg_len_c;
            cnt <= last ? '0 : cnt + L2'(1);
        end
    end

    // Per-channel accumulators. The first beat of a frame overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NO_CH; ch++) acc[ch] <= '0;
        end else if (bus.flush) begin
            for (int ch = 0; ch < NO_CH; ch++) acc[ch] <= '0;
        end else if (take_beat) begin
            for (int ch = 0; ch < NO_CH; ch++) acc[ch] <= acc_nxt[ch];
        end
    end

    // Output register. It holds while stalled and reloads when a drain and a last beat coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            dout_q    <= '0;
            sat_q     <= '0;
        end else if (last) begin
            out_vld_q <= 1'b1;
            dout_q    <= dout_d;
            sat_q     <= sat_d;
        end else if (bus.out_rdy) begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.in_rdy   = in_rdy_w;
    assign bus.out_vld  = out_vld_q;
    assign bus.data_out = dout_q;
    assign bus.sat_out  = sat_q;
endmodule
